// File: rtl/hex_scan_ctrl.sv
// Multiplexed hex display refresher: one shared decoder scans the digits.
// Define HEX_BLANK_EN to blank leading-zero digits above HEX0.
module hex_scan_ctrl #(
  parameter int NUM_DIGITS  = 6,
  parameter int HOLD_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [23:0] value,
  output logic        busy,
  output logic        done,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);
  localparam logic [3:0] HMAX = 4'(HOLD_CYCLES - 1);

  logic [1:0]  state;
  logic [23:0] cap;
  logic [2:0]  idx;
  logic [3:0]  cnt;
  logic [6:0]  seg [6];
  logic [3:0]  nib;
  logic [6:0]  dec;
  logic [6:0]  wr;

  assign nib = cap[{idx, 2'b00} +: 4];

  always_comb begin
    dec = 7'h7F;
    case (nib)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      4'hF: dec = 7'h0E;
      default: dec = 7'h7F;
    endcase
  end

`ifdef HEX_BLANK_EN
  // Blank when this nibble and every shown nibble above it are zero.
  logic upper_zero;

  always_comb begin
    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++)
      if (j >= int'(idx) && cap[4*j +: 4] != 4'd0)
        upper_zero = 1'b0;
  end

  assign wr = (idx != 3'd0 && upper_zero) ? 7'h7F : dec;
`else
  assign wr = dec;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cap   <= '0;
      idx   <= '0;
      cnt   <= '0;
      for (int k = 0; k < 6; k++)
        seg[k] <= 7'h7F;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            cap   <= value;
            idx   <= '0;
            cnt   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (cnt == HMAX) begin
            seg[idx] <= wr;
            cnt      <= '0;
            if (idx == LAST)
              state <= DONE;
            else
              idx <= idx + 3'd1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  assign hex0 = seg[0];
  assign hex1 = seg[1];
  assign hex2 = seg[2];
  assign hex3 = seg[3];
  assign hex4 = seg[4];
  assign hex5 = seg[5];

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl: default build plus a 3-digit, 1-cycle-hold copy.
// Expected segments come from a digit-level model applied at refresh times.
module tb_hex_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        load0, load1;
  logic [23:0] value0, value1;
  logic        busy0, done0, busy1, done1;
  logic [6:0]  a0, a1, a2, a3, a4, a5;
  logic [6:0]  b0, b1, b2, b3, b4, b5;

  int tests = 0;
  int fails = 0;

  logic [6:0] mh [2][6];

  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    logic [23:0] v;
    logic [41:0] hx;
    int          mode;
  } vec_t;

  always #5 clock = ~clock;

  hex_scan_ctrl u0 (
    .clock(clock), .reset(reset), .load(load0), .value(value0),
    .busy(busy0), .done(done0),
    .hex0(a0), .hex1(a1), .hex2(a2),
    .hex3(a3), .hex4(a4), .hex5(a5)
  );

  hex_scan_ctrl #(.NUM_DIGITS(3), .HOLD_CYCLES(1)) u1 (
    .clock(clock), .reset(reset), .load(load1), .value(value1),
    .busy(busy1), .done(done1),
    .hex0(b0), .hex1(b1), .hex2(b2),
    .hex3(b3), .hex4(b4), .hex5(b5)
  );

  function automatic logic [6:0] eseg(logic [23:0] v, int k, int n);
    logic [3:0] q;
    if (k >= n) return 7'h7F;
`ifdef HEX_BLANK_EN
    if (k > 0) begin
      bit z = 1'b1;
      for (int j = k; j < n; j++)
        if (v[4*j +: 4] != 4'd0) z = 1'b0;
      if (z) return 7'h7F;
    end
`endif
    q = v[4*k +: 4];
    return SEG[q];
  endfunction

  function automatic logic [43:0] obs(int s);
    if (s == 0) return {busy0, done0, a5, a4, a3, a2, a1, a0};
    return {busy1, done1, b5, b4, b3, b2, b1, b0};
  endfunction

  function automatic logic [41:0] hexes(int s);
    if (s == 0) return {a5, a4, a3, a2, a1, a0};
    return {b5, b4, b3, b2, b1, b0};
  endfunction

  function automatic logic [43:0] want(int s, logic b, logic d);
    return {b, d, mh[s][5], mh[s][4], mh[s][3],
            mh[s][2], mh[s][1], mh[s][0]};
  endfunction

  task automatic check(string nm, int s, logic b, logic d);
    logic [43:0] g, w;
    g = obs(s);
    w = want(s, b, d);
    tests++;
    if (g !== w) begin
      fails++;
      $display("FAIL %s dut%0d got %h want %h @%0t",
               nm, s, g, w, $time);
    end
  endtask

  task automatic check_hex(string nm, int s, logic [41:0] w);
    logic [41:0] g;
    g = hexes(s);
    tests++;
    if (g !== w) begin
      fails++;
      $display("FAIL %s dut%0d hex got %h want %h", nm, s, g, w);
    end
  endtask

  task automatic drive(int s, logic l, logic [23:0] v);
    if (s == 0) begin
      load0  = l;
      value0 = v;
    end else begin
      load1  = l;
      value1 = v;
    end
  endtask

  task automatic blank_model();
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 6; k++)
        mh[s][k] = 7'h7F;
  endtask

  // mode 0: quiet, 1: random load/value noise, 2: zero loads at edges 3, 12
  task automatic run_refresh(int s, logic [23:0] v, int mode);
    int n, h;
    n = (s != 0) ? 3 : 6;
    h = (s != 0) ? 1 : 2;
    @(negedge clock);
    drive(s, 1'b1, v);
    @(posedge clock);
    #1;
    check("accept", s, 1'b1, 1'b0);
    for (int e = 1; e <= n * h + 1; e++) begin
      if (mode == 1)
        drive(s, 1'($urandom_range(0, 1)), 24'($urandom));
      else if (mode == 2 && (e == 3 || e == 12))
        drive(s, 1'b1, 24'h0);
      else
        drive(s, 1'b0, 24'($urandom));
      @(posedge clock);
      #1;
      if (e <= n * h && e % h == 0)
        mh[s][e/h-1] = eseg(v, e / h - 1, n);
      if (e < n * h)
        check("scan", s, 1'b1, 1'b0);
      else if (e == n * h)
        check("done", s, 1'b1, 1'b1);
      else
        check("idle", s, 1'b0, 1'b0);
    end
    drive(s, 1'b0, 24'($urandom));
  endtask

  vec_t tbl [4];

  initial begin
    tbl[0] = '{24'h123456,
      {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 0};
    tbl[1] = '{24'hABCDEF,
      {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 2};
    tbl[2] = '{24'hF0E0D0,
      {7'h0E, 7'h40, 7'h06, 7'h40, 7'h21, 7'h40}, 1};
    tbl[3] = '{24'h789ABC,
      {7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46}, 0};

    reset  = 1'b1;
    load0  = 1'b0;
    load1  = 1'b0;
    value0 = '0;
    value1 = '0;
    repeat (2) @(posedge clock);
    #1;
    blank_model();
    check("reset", 0, 1'b0, 1'b0);
    check("reset", 1, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_refresh(0, tbl[i].v, tbl[i].mode);
      check_hex("table", 0, tbl[i].hx);
    end

    run_refresh(1, 24'hFFFFFF, 0);
    check_hex("nd3", 1,
      {7'h7F, 7'h7F, 7'h7F, 7'h0E, 7'h0E, 7'h0E});

    // Reset mid-refresh: no done, all blank, load at reset edge ignored.
    @(negedge clock);
    drive(0, 1'b1, 24'h888888);
    @(posedge clock);
    #1;
    drive(0, 1'b0, 24'h0);
    for (int e = 1; e <= 4; e++) @(posedge clock);
    #1;
    reset = 1'b1;
    drive(0, 1'b1, 24'h555555);
    @(posedge clock);
    #1;
    blank_model();
    check("rst_abort", 0, 1'b0, 1'b0);
    check("rst_abort", 1, 1'b0, 1'b0);
    reset = 1'b0;
    drive(0, 1'b0, 24'h0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clock);
      #1;
      check("no_done", 0, 1'b0, 1'b0);
    end

    run_refresh(0, 24'h000000, 0);
`ifdef HEX_BLANK_EN
    check_hex("blank0", 0,
      {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    run_refresh(0, 24'h00002A, 0);
    check_hex("blank2a", 0,
      {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h08});
`else
    check_hex("zero", 0,
      {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
`endif

    for (int i = 0; i < 20; i++) begin
      logic [23:0] v;
      v = 24'($urandom) & (24'hFFFFFF >> (4 * $urandom_range(0, 5)));
      run_refresh(0, v, 1);
    end
    for (int i = 0; i < 10; i++) begin
      logic [23:0] v;
      v = 24'($urandom) & (24'hFFFFFF >> (4 * $urandom_range(0, 5)));
      run_refresh(1, v, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hex_scan_ctrl.md
HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 6, number of digits refreshed per load; legal range 1..6.
REQ-002 Parameter HOLD_CYCLES, default 2, cycles the shared decoder is held per digit; legal range 1..15.
REQ-003 clock  input  1  rising-edge clock; sole clock of the block.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load  input  1  request to display value; sampled on clock edges.
REQ-006 value  input  24  six hex nibbles; nibble k = value[4k+3:4k] drives HEXk.
REQ-007 busy  output  1  high while a refresh is in progress.
REQ-008 done  output  1  one-cycle pulse marking the end of a refresh.
REQ-009 HEX0..HEX5  output  7 each  registered segment outputs; bit0=a .. bit6=g; active-low.

Function
REQ-010 The block SHALL contain exactly one hex-to-7-segment decoder, time-shared across all digits.
REQ-011 Decoder map (active-low, hex) SHALL be: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-012 FSM states SHALL be IDLE, SCAN, DONE.
REQ-013 IDLE: busy=0, done=0; load=1 captures value into an internal register, clears digit index and hold counter, and moves to SCAN.
REQ-014 SCAN: busy=1; decoder input is captured nibble [index]; hold counter runs 0..HOLD_CYCLES-1.
REQ-015 On the edge where the hold counter equals HOLD_CYCLES-1, HEX[index] SHALL be written, counter cleared, index incremented.
REQ-016 When index NUM_DIGITS-1 is written, the FSM SHALL move to DONE.
REQ-017 DONE: busy=1, done=1 for exactly one cycle, then IDLE unconditionally.
REQ-018 Latency: load accepted at edge 0 -> HEX0 updated at edge HOLD_CYCLES, HEXk at edge (k+1)*HOLD_CYCLES, done high during the cycle after edge NUM_DIGITS*HOLD_CYCLES.
REQ-019 load while busy=1 (SCAN or DONE) SHALL be ignored; the captured value SHALL NOT change mid-refresh.
REQ-020 load in the same cycle done is high SHALL be ignored; it is accepted only from IDLE.
REQ-021 HEX outputs not yet rewritten in a refresh SHALL hold their previous values; outputs with index >= NUM_DIGITS SHALL stay 7F permanently.
REQ-022 Changes on value outside the load cycle SHALL have no effect on outputs.

Reset
REQ-023 reset=1 on a rising edge SHALL force IDLE, busy=0, done=0, index=0, counter=0, captured value=0, HEX0..HEX5=7F.
REQ-024 reset SHALL take priority over load and over an in-progress SCAN; an aborted refresh SHALL NOT emit done.
REQ-025 First load SHALL be accepted on the first edge after reset deasserts.

Configuration
REQ-026 Macro HEX_BLANK_EN SHALL enable leading-zero blanking; absent, all NUM_DIGITS digits show their decoded nibble.
REQ-027 With HEX_BLANK_EN: digit k>0 SHALL be written 7F when all nibbles k..NUM_DIGITS-1 of the captured value are 0; HEX0 always shows its decoded nibble, so value 0 shows a single "0".
REQ-028 With HEX_BLANK_EN, timing, busy and done behaviour SHALL be identical to the non-blanking build.

Verification
REQ-029 Reset, then load value=24'h123456, defaults -> HEX0=02,HEX1=12,HEX2=19,HEX3=30,HEX4=24,HEX5=79; done high during the cycle after edge 12.
REQ-030 Load 24'hABCDEF, then pulse load with 24'h000000 at edges 3 and 12 (busy=1 at each) -> both ignored; HEX5..HEX0=08,03,46,21,06,0E.
REQ-031 Assert reset at edge 5 of a refresh of 24'h888888 -> all HEX=7F on next edge, busy=0, no done pulse.
REQ-032 HEX_BLANK_EN defined, load 24'h00002A -> HEX0=08, HEX1=24, HEX2..HEX5=7F; load 24'h0 -> HEX0=40, others 7F.
REQ-033 NUM_DIGITS=3, HOLD_CYCLES=1, load 24'hFFFFFF -> HEX0..HEX2=0E at edges 1..3, done during cycle after edge 3, HEX3..HEX5 remain 7F.
